// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer.
//   TONE_HZ     : frequency table (Hz), 16 entries, indexed by the latched tone select
//   HP_W        : width of the square-wave half-period limit
//   state_t     : sequencer FSM encoding
//   half_period : elaboration-time half-period limit for one table entry
package tone_pkg;

    localparam int HP_W = 20;

    localparam int unsigned TONE_HZ [0:15] = '{
        261, 500, 700, 880,
        1047, 1175, 1319, 1397,
        1568, 1760, 1976, 2093,
        2349, 2637, 2794, 3136
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Square-wave counter limit: counts 0..HP, so each half period is HP+1
    // clocks. A tone too fast for the clock collapses to HP=0.
    function automatic logic [HP_W-1:0] half_period(input int unsigned sys_freq,
                                                    input int unsigned hz);
        int unsigned q;
        q = sys_freq / (2 * hz);
        if (q == 0) return '0;
        return HP_W'(q - 1);
    endfunction

endpackage

// File: rtl/tone_pwm.sv
// PWM back end: free-running counter plus comparator with a registered
// audio bit.
//   clock, resetn : system clock, async active-low reset
//   en            : comparator result is passed through only while high
//   duty          : compare level, audio is high while counter < duty
//   audio         : registered PWM audio bit
module tone_pwm
    import tone_pkg::*;
#(
    parameter int PWM_W = 10
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic [PWM_W-1:0] duty,
    output logic             audio
);

    logic [PWM_W-1:0] pwm_cnt;

    // The counter never restarts on tone entry; the audio phase is tied to
    // the time since reset, not to the start of a tone.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt <= '0;
            audio   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            audio   <= en && (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays one tone per start request: TONE for dur_ms milliseconds, then a
// silent GAP of GAP_MS milliseconds, then a one-cycle done pulse.
//   clock, resetn : system clock, async active-low reset
//   start, stop   : level-sampled play request / abort
//   tone_sel      : index into the frequency table
//   dur_ms        : tone length in ms (0 = gap only)
//   volume        : duty swing around mid-scale
//   busy          : high during TONE and GAP
//   done          : one-cycle pulse after a gap completes normally
//   audioEn       : amplifier enable, high during TONE
//   audioOut      : PWM audio bit
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int SYSTEM_FREQ = 50_000_000,
    parameter int SEL_W       = 2,
    parameter int DUR_W       = 12,
    parameter int PWM_W       = 10,
    parameter int MS_CYCLES   = SYSTEM_FREQ / 1000,
    parameter int GAP_MS      = 50
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic [SEL_W-1:0] tone_sel,
    input  logic [DUR_W-1:0] dur_ms,
    input  logic [PWM_W-2:0] volume,
    output logic             busy,
    output logic             done,
    output logic             audioEn,
    output logic             audioOut
);

    localparam int NUM_TONES = 2 ** SEL_W;
    localparam int MS_W      = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);
    localparam logic [PWM_W-1:0] MID      = {1'b1, {(PWM_W-1){1'b0}}};

    state_t state, next_state;

    logic [SEL_W-1:0] sel_lat;
    logic [DUR_W-1:0] dur_lat;
    logic [PWM_W-2:0] vol_lat;

    logic [MS_W-1:0]  ms_cnt;
    logic [DUR_W-1:0] ms_elapsed;
    logic             ms_last, tone_end, gap_end;

    logic [HP_W-1:0]  hp;
    logic [HP_W-1:0]  sq_cnt;
    logic             sq;

    logic [PWM_W-1:0] duty;
    logic             pwm_en;
    logic             done_d;

    // Half-period limits are constants per table entry; the latched select
    // only muxes between them, so no divider is built.
    logic [HP_W-1:0] hp_tab [NUM_TONES];

    for (genvar g = 0; g < NUM_TONES; g++) begin : g_hp
        localparam logic [HP_W-1:0] HP_G = half_period(SYSTEM_FREQ, TONE_HZ[g]);
        assign hp_tab[g] = HP_G;
    end

    assign hp = hp_tab[sel_lat];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign ms_last  = (ms_cnt == MS_LAST);
    assign tone_end = ms_last && (ms_elapsed == dur_lat - DUR_W'(1));
    assign gap_end  = ms_last && (ms_elapsed == GAP_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        done_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                // stop beats a simultaneous start
                if (start && !stop)
                    next_state = (dur_ms != '0) ? ST_TONE : ST_GAP;
            end
            ST_TONE: begin
                if (stop)          next_state = ST_IDLE;
                else if (tone_end) next_state = ST_GAP;
            end
            ST_GAP: begin
                if (stop) begin
                    next_state = ST_IDLE;
                end else if (gap_end) begin
                    next_state = ST_IDLE;
                    done_d     = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch: sampled only in IDLE, frozen while busy
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel_lat <= '0;
            dur_lat <= '0;
            vol_lat <= '0;
        end else if (state == ST_IDLE && start && !stop) begin
            sel_lat <= tone_sel;
            dur_lat <= dur_ms;
            vol_lat <= volume;
        end
    end

    // ------------------------------------------------------------------
    // Millisecond timebase, restarted on every state change so TONE and
    // GAP each measure their own length from their first cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ms_cnt     <= '0;
            ms_elapsed <= '0;
        end else if (state == ST_IDLE || next_state != state) begin
            ms_cnt     <= '0;
            ms_elapsed <= '0;
        end else if (ms_last) begin
            ms_cnt     <= '0;
            ms_elapsed <= ms_elapsed + DUR_W'(1);
        end else begin
            ms_cnt     <= ms_cnt + MS_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Square wave: runs only while staying in TONE, so it is already
    // cleared on the first TONE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sq_cnt <= '0;
            sq     <= 1'b0;
        end else if (state == ST_TONE && next_state == ST_TONE) begin
            if (sq_cnt == hp) begin
                sq_cnt <= '0;
                sq     <= ~sq;
            end else begin
                sq_cnt <= sq_cnt + HP_W'(1);
            end
        end else begin
            sq_cnt <= '0;
            sq     <= 1'b0;
        end
    end

    // MID +/- volume stays in 1..2**PWM_W-1 because volume is one bit narrower.
    assign duty = sq ? (MID + PWM_W'(vol_lat)) : (MID - PWM_W'(vol_lat));

    // Gate on the next state too, so the registered audio bit is already
    // low on the first cycle after TONE ends or is aborted.
    assign pwm_en = (state == ST_TONE) && (next_state == ST_TONE);

    tone_pwm #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clock  (clock),
        .resetn (resetn),
        .en     (pwm_en),
        .duty   (duty),
        .audio  (audioOut)
    );

    // ------------------------------------------------------------------
    // Status outputs follow the state being entered, so done and the
    // busy drop land in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            audioEn <= 1'b0;
        end else begin
            busy    <= (next_state != ST_IDLE);
            done    <= done_d;
            audioEn <= (next_state == ST_TONE);
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

    localparam int SF    = 100_000;
    localparam int MS    = 100;
    localparam int GAPMS = 2;
    localparam int GAPC  = GAPMS * MS;
    localparam int TONE_TB [4] = '{261, 500, 700, 880};

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  tone_sel = '0;
    logic [11:0] dur_ms = '0;
    logic [8:0]  volume = '0;
    logic        busy, done, audioEn, audioOut;

    tone_sequencer #(
        .SYSTEM_FREQ (SF),
        .SEL_W       (2),
        .DUR_W       (12),
        .PWM_W       (10),
        .MS_CYCLES   (MS),
        .GAP_MS      (GAPMS)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .tone_sel (tone_sel),
        .dur_ms   (dur_ms),
        .volume   (volume),
        .busy     (busy),
        .done     (done),
        .audioEn  (audioEn),
        .audioOut (audioOut)
    );

    always #5 clock = ~clock;

    // cycles since reset release; matches the free-running PWM phase
    int cyc;
    always @(posedge clock or negedge resetn)
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;

    typedef struct {
        int k;
        int end_cyc;
        int done;
        int en_cnt;
        int aud_cnt;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int busy_until = -1;
    int stop_at = -1;
    int last_acc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference outcome of one accepted request, from the timing rules:
    // TONE occupies cycles k+1..k+T, GAP the next GAPC cycles, done after.
    // audioOut at cycle c is (pwm phase at c-1) < duty at c-1.
    function automatic exp_t model(int k, int d, int v, int s, int stop_t);
        exp_t e;
        int t_len, gap_end, tone_last, hp, duty, aud, idx;
        t_len   = d * MS;
        gap_end = k + t_len + GAPC;
        hp      = SF / (2 * TONE_TB[s]) - 1;
        e.k       = k;
        e.done    = (stop_t < 0) ? 1 : 0;
        e.end_cyc = (stop_t < 0) ? gap_end + 1 : stop_t + 1;
        tone_last = (stop_t >= 0 && stop_t < k + t_len) ? stop_t : k + t_len;
        e.en_cnt  = (d == 0) ? 0 : tone_last - k;
        aud = 0;
        for (int c = k + 2; c <= tone_last; c++) begin
            idx  = c - 1 - (k + 1);
            duty = (((idx / (hp + 1)) % 2) == 1) ? 512 + v : 512 - v;
            if (((c - 1) % 1024) < duty) aud++;
        end
        e.aud_cnt = aud;
        return e;
    endfunction

    // One clock of stimulus; a planned stop for the current request is
    // asserted automatically at its cycle.
    task automatic drive_cycle(input bit st, input bit sp_idle, input int s,
                               input int d, input int v, input int stop_off);
        bit sp;
        exp_t e;
        @(posedge clock);
        #1;
        sp = (cyc == stop_at) || (sp_idle && cyc > busy_until);
        start    = st;
        stop     = sp;
        tone_sel = 2'(s);
        dur_ms   = 12'(d);
        volume   = 9'(v);
        if (st && !sp && cyc > busy_until) begin
            stop_at = (stop_off > 0) ? cyc + stop_off : -1;
            e = model(cyc, d, v, s, stop_at);
            sb.push_back(e);
            busy_until = e.end_cyc - 1;
            last_acc   = cyc;
        end
    endtask

    task automatic drive_idle();
        drive_cycle(1'b0, 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 511)), -1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            drive_idle();
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: pops the expected record whenever busy drops.
    int   en_acc, aud_acc;
    bit   busy_q;
    exp_t mon_e;
    always @(negedge clock) begin
        if (!resetn) begin
            en_acc  = 0;
            aud_acc = 0;
            busy_q  = 1'b0;
        end else begin
            en_acc  += int'(audioEn);
            aud_acc += int'(audioOut);
            if (busy && !busy_q) begin
                if (sb.size() == 0) check("busy_rise_unexpected", 1, 0);
                else                check("busy_rise_cycle", cyc, sb[0].k + 1);
            end
            if (busy_q && !busy) begin
                if (sb.size() == 0) begin
                    check("busy_fall_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("end_cycle", cyc, mon_e.end_cyc);
                    check("done_pulse", int'(done), mon_e.done);
                    check("audioEn_cycles", en_acc, mon_e.en_cnt);
                    check("audioOut_high_cycles", aud_acc, mon_e.aud_cnt);
                end
                en_acc  = 0;
                aud_acc = 0;
            end else if (done) begin
                check("spurious_done", 1, 0);
            end
            busy_q = busy;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, dn, k, d, so;

        repeat (3) @(negedge clock);
        check("reset_outputs", int'({busy, done, audioEn, audioOut}), 0);
        #1 resetn = 1'b1;

        // sel 0, 3 ms, vol 400: full tone + gap + done
        drive_cycle(1'b1, 1'b0, 0, 3, 400, -1);
        wait_idle(1000);

        // dur 0: gap only, done 201 clocks after start
        drive_cycle(1'b1, 1'b0, 2, 0, 300, -1);
        wait_idle(500);

        // stop on clock 150 of TONE
        drive_cycle(1'b1, 1'b0, 1, 3, 250, 150);
        wait_idle(500);

        // start+stop together in IDLE: stop wins
        drive_cycle(1'b1, 1'b1, 3, 2, 100, -1);
        drive_idle();
        @(negedge clock);
        check("start_stop_idle_busy", int'(busy), 0);

        // start during TONE ignored; restart in the done cycle
        drive_cycle(1'b1, 1'b0, 0, 2, 200, -1);
        k = last_acc;
        while (cyc < k + 50) drive_idle();
        drive_cycle(1'b1, 1'b0, 3, 1, 0, -1);
        while (cyc < busy_until) drive_idle();
        drive_cycle(1'b1, 1'b0, 1, 1, 100, -1);
        check("restart_in_done_cycle", last_acc, k + 2 * MS + GAPC + 1);
        wait_idle(1000);

        // vol 0: exactly half of any 1024-cycle window is high
        drive_cycle(1'b1, 1'b0, 2, 11, 0, -1);
        drive_idle();
        hi = 0;
        for (int j = 0; j < 1024; j++) begin
            drive_idle();
            @(negedge clock);
            hi += int'(audioOut);
        end
        check("vol0_half_duty", hi, 512);
        wait_idle(2000);

        // reset in the middle of GAP
        drive_cycle(1'b1, 1'b0, 0, 1, 300, -1);
        k = last_acc;
        while (cyc < k + MS + 50) drive_idle();
        check("busy_before_reset", int'(busy), 1);
        #2 resetn = 1'b0;
        #1 check("async_reset_outputs", int'({busy, done, audioEn, audioOut}), 0);
        sb.delete();
        busy_until = -1;
        stop_at    = -1;
        @(negedge clock);
        @(negedge clock);
        #1 resetn = 1'b1;
        dn = 0;
        for (int j = 0; j < 300; j++) begin
            drive_idle();
            @(negedge clock);
            dn += int'(done) + int'(busy);
        end
        check("quiet_after_reset", dn, 0);

        // randomized traffic
        for (int n = 0; n < 12000; n++) begin
            d  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            so = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, d * MS + GAPC)) : -1;
            drive_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0,
                        int'($urandom_range(0, 3)), d, int'($urandom_range(0, 511)), so);
        end
        wait_idle(3000);
        drive_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter SYSTEM_FREQ, 50_000_000, clock frequency in Hz.
REQ-002 Parameter SEL_W, 2, tone-select width; 2**SEL_W tones, max 16.
REQ-003 Parameter DUR_W, 12, tone-duration width in ms.
REQ-004 Parameter PWM_W, 10, PWM counter/duty width.
REQ-005 Parameter MS_CYCLES, SYSTEM_FREQ/1000, clocks per ms tick; overridable for simulation.
REQ-006 Parameter GAP_MS, 50, silent gap after each tone, in ms.
REQ-007 Port clock  input  1  single system clock; all logic on rising edge.
REQ-008 Port resetn  input  1  asynchronous, active-low reset.
REQ-009 Port start  input  1  request to play one tone; sampled only when not busy.
REQ-010 Port stop  input  1  abort current tone/gap.
REQ-011 Port tone_sel  input  SEL_W  tone index into the shared frequency table.
REQ-012 Port dur_ms  input  DUR_W  tone length in ms.
REQ-013 Port volume  input  PWM_W-1  duty swing around mid-scale.
REQ-014 Port busy  output  1  high in TONE and GAP.
REQ-015 Port done  output  1  one-cycle pulse on normal completion.
REQ-016 Port audioEn  output  1  audio amplifier enable.
REQ-017 Port audioOut  output  1  PWM audio bit.

Function
REQ-018 FSM states IDLE, TONE, GAP; start and stop are level-sampled each clock.
REQ-019 IDLE & start & !stop & dur_ms!=0: latch tone_sel, dur_ms, volume; next cycle TONE, busy=1, audioEn=1.
REQ-020 IDLE & start & dur_ms==0: no TONE; go to GAP next cycle (silent gap, then done).
REQ-021 Start while busy is ignored; latched parameters do not change mid-tone.
REQ-022 TONE lasts exactly dur_ms*MS_CYCLES clocks, then GAP.
REQ-023 GAP lasts exactly GAP_MS*MS_CYCLES clocks; audioEn=0, audioOut=0 throughout.
REQ-024 On last GAP clock: next state IDLE, done=1 and busy=0 in the same cycle; a start in that cycle is accepted.
REQ-025 stop in TONE or GAP: next cycle IDLE, busy=0, audioEn=0; no done pulse; stop wins over simultaneous start.
REQ-026 Half-period limit HP = SYSTEM_FREQ/(2*TONE_HZ[sel]) - 1, computed at elaboration, 20-bit unsigned.
REQ-027 Square-wave counter counts 0..HP and toggles sq on wrap; counter and sq cleared on entry to TONE.
REQ-028 Duty = MID+volume when sq=1, MID-volume when sq=0, MID = 2**(PWM_W-1); no overflow possible by width.
REQ-029 PWM counter free-runs PWM_W bits; audioOut = registered (pwm_cnt < duty) in TONE, 0 otherwise.
REQ-030 ms tick counter resets on every state entry; duration counter DUR_W bits, no wrap (terminates at dur_ms).

Reset
REQ-031 resetn low: state IDLE, busy=0, done=0, audioEn=0, audioOut=0, all counters and sq 0, latched fields 0.
REQ-032 Reset asserted mid-tone stops output within the same cycle (asynchronous); no done after release.

Structure
REQ-033 Package tone_pkg holds TONE_HZ[0:15] (index 0..3 = 261, 500, 700, 880 Hz), state encoding, HP width constant.
REQ-034 One sub-module tone_pwm (PWM counter + comparator, duty in, audio bit out) is instantiated once.

Verification (MS_CYCLES=100, SYSTEM_FREQ=100_000, GAP_MS=2)
REQ-035 start, sel=0, dur=3, vol=400 -> busy next cycle, sq period 2*(191) clocks, TONE 300 clocks, GAP 200, done 1 cycle.
REQ-036 start with dur_ms=0 -> audioEn never high, done exactly 201 clocks after start.
REQ-037 stop at clock 150 of TONE -> IDLE next cycle, audioOut=0, no done.
REQ-038 start pulsed during TONE with sel=3 -> ignored, HP stays 190; start in done cycle -> new TONE next clock.
REQ-039 vol=0 -> duty fixed 512, audioOut high 512/1024 of cycles regardless of sq.
REQ-040 resetn low mid-GAP -> all outputs 0 immediately; after release, IDLE with no spurious done.
